// File: rtl/cardinal_nic_pkg.sv
// Shared constants for the cardinal ring network interface controller.
// Holds the PE register map and the default packet geometry.
package cardinal_nic_pkg;

    localparam int DEF_DATA_WIDTH = 64;
    localparam int DEF_VC_BIT     = 63;

    localparam logic [1:0] ADDR_IN_DATA  = 2'b00;
    localparam logic [1:0] ADDR_IN_STAT  = 2'b01;
    localparam logic [1:0] ADDR_OUT_DATA = 2'b10;
    localparam logic [1:0] ADDR_OUT_STAT = 2'b11;

endpackage

// File: rtl/nic_channel_buffer.sv
// One-entry packet register with a full flag.
// Load wins over clear, although the NIC never issues both in one cycle.
module nic_channel_buffer #(
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic             clear,
    input  logic [WIDTH-1:0] load_data,
    output logic [WIDTH-1:0] data,
    output logic             full
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            data <= '0;
            full <= 1'b0;
        end else if (load) begin
            data <= load_data;
            full <= 1'b1;
        end else if (clear) begin
            full <= 1'b0;
        end
    end

endmodule

// File: rtl/cardinal_nic.sv
// NIC between one PE and a cardinal_router PE port: register-mapped PE side,
// send/ready ring side, injection gated by ring polarity against the packet VC bit.
import cardinal_nic_pkg::*;

module cardinal_nic #(
    parameter int DATA_WIDTH = DEF_DATA_WIDTH,
    parameter int VC_BIT     = DEF_VC_BIT
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [1:0]            addr,
    input  logic [DATA_WIDTH-1:0] d_in,
    output logic [DATA_WIDTH-1:0] d_out,
    input  logic                  nicEn,
    input  logic                  nicEnWr,
    input  logic                  net_si,
    output logic                  net_ri,
    input  logic [DATA_WIDTH-1:0] net_di,
    output logic                  net_so,
    input  logic                  net_ro,
    output logic [DATA_WIDTH-1:0] net_do,
    input  logic                  net_polarity
);

    logic                  pe_rd;
    logic                  pe_wr;
    logic                  in_load;
    logic                  in_clear;
    logic                  out_load;
    logic                  in_full;
    logic                  out_full;
    logic [DATA_WIDTH-1:0] in_buf;
    logic [DATA_WIDTH-1:0] out_buf;

    assign pe_rd = nicEn && !nicEnWr;
    assign pe_wr = nicEn && nicEnWr;

    // Handshake outputs are gated by rst so nothing leaks out while reset is held.
    assign net_ri = !in_full && !rst;
    assign net_so = out_full && net_ro && (out_buf[VC_BIT] == net_polarity) && !rst;
    assign net_do = out_buf;

    assign in_load  = net_si && net_ri;
    assign in_clear = pe_rd && (addr == ADDR_IN_DATA) && in_full;
    // Pre-edge out_full governs, so a write in the injecting cycle is dropped.
    assign out_load = pe_wr && (addr == ADDR_OUT_DATA) && !out_full;

    nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_in_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (in_load),
        .clear     (in_clear),
        .load_data (net_di),
        .data      (in_buf),
        .full      (in_full)
    );

    nic_channel_buffer #(.WIDTH(DATA_WIDTH)) u_out_buf (
        .clk       (clk),
        .rst       (rst),
        .load      (out_load),
        .clear     (net_so),
        .load_data (d_in),
        .data      (out_buf),
        .full      (out_full)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            d_out <= '0;
        end else if (pe_rd) begin
            case (addr)
                ADDR_IN_DATA:  d_out <= in_buf;
                ADDR_IN_STAT:  d_out <= {{(DATA_WIDTH-1){1'b0}}, in_full};
                ADDR_OUT_STAT: d_out <= {{(DATA_WIDTH-1){1'b0}}, out_full};
                default:       d_out <= '0;
            endcase
        end
    end

endmodule

// File: tb/tb_cardinal_nic.sv
// Directed self-checking bench for cardinal_nic.
// Inputs change 1 ns after the rising edge; outputs are sampled mid-cycle.
module tb_cardinal_nic;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  addr;
    logic [63:0] d_in;
    logic [63:0] d_out;
    logic        nicEn;
    logic        nicEnWr;
    logic        net_si;
    logic        net_ri;
    logic [63:0] net_di;
    logic        net_so;
    logic        net_ro;
    logic [63:0] net_do;
    logic        net_polarity;

    int n_cmp = 0;
    int n_bad = 0;

    localparam logic [63:0] PKT_AA   = 64'h8000_0000_0000_00AA;
    localparam logic [63:0] PKT_55   = 64'h0000_0000_0000_0055;
    localparam logic [63:0] PKT_11   = 64'h8000_0000_0000_0011;
    localparam logic [63:0] PKT_RX   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] PKT_RX2  = 64'hFEDC_BA98_7654_3210;

    always #5 clk = ~clk;

    cardinal_nic dut (
        .clk          (clk),
        .rst          (rst),
        .addr         (addr),
        .d_in         (d_in),
        .d_out        (d_out),
        .nicEn        (nicEn),
        .nicEnWr      (nicEnWr),
        .net_si       (net_si),
        .net_ri       (net_ri),
        .net_di       (net_di),
        .net_so       (net_so),
        .net_ro       (net_ro),
        .net_do       (net_do),
        .net_polarity (net_polarity)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pe_write(input logic [1:0] a, input logic [63:0] d);
        addr = a; d_in = d; nicEn = 1'b1; nicEnWr = 1'b1;
        tick();
        nicEn = 1'b0; nicEnWr = 1'b0;
    endtask

    task automatic pe_read(input logic [1:0] a);
        addr = a; nicEn = 1'b1; nicEnWr = 1'b0;
        tick();
        nicEn = 1'b0;
    endtask

    task automatic test_reset();
        #2;
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL rst_so got %b exp 0", net_so); end
        n_cmp++; if (net_ri !== 1'b0) begin n_bad++; $display("FAIL rst_ri got %b exp 0", net_ri); end
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL rst_dout got %h exp 0", d_out); end
        n_cmp++; if (net_do !== 64'h0) begin n_bad++; $display("FAIL rst_do got %h exp 0", net_do); end
        tick();
        rst = 1'b0;
        tick();
        // Load an injectable packet, then hit reset with injection conditions live.
        net_ro = 1'b1; net_polarity = 1'b0;
        pe_write(2'b10, PKT_AA);
        net_polarity = 1'b1; #1;
        n_cmp++; if (net_so !== 1'b1) begin n_bad++; $display("FAIL pre_rst_so got %b exp 1", net_so); end
        rst = 1'b1; #1;
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL midrst_so got %b exp 0", net_so); end
        n_cmp++; if (net_ri !== 1'b0) begin n_bad++; $display("FAIL midrst_ri got %b exp 0", net_ri); end
        tick();
        rst = 1'b0; net_ro = 1'b0; net_polarity = 1'b0; #1;
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL post_rst_ri got %b exp 1", net_ri); end
        n_cmp++; if (net_do !== 64'h0) begin n_bad++; $display("FAIL post_rst_do got %h exp 0", net_do); end
        tick();
        pe_read(2'b01);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL post_rst_instat got %h exp 0", d_out); end
        pe_read(2'b11);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL post_rst_outstat got %h exp 0", d_out); end
    endtask

    task automatic test_injection();
        net_ro = 1'b1; net_polarity = 1'b0;
        pe_write(2'b10, PKT_AA);
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL inj_pol0_so got %b exp 0", net_so); end
        net_polarity = 1'b1; #1;
        n_cmp++; if (net_so !== 1'b1) begin n_bad++; $display("FAIL inj_pol1_so got %b exp 1", net_so); end
        n_cmp++; if (net_do !== PKT_AA) begin n_bad++; $display("FAIL inj_do got %h exp %h", net_do, PKT_AA); end
        tick();
        net_polarity = 1'b0; #1;
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL inj_after_so got %b exp 0", net_so); end
        net_polarity = 1'b1; #1;
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL inj_noreplay_so got %b exp 0", net_so); end
        pe_read(2'b11);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL inj_outstat got %h exp 0", d_out); end
        n_cmp++; if (net_do !== PKT_AA) begin n_bad++; $display("FAIL inj_retain got %h exp %h", net_do, PKT_AA); end
        net_ro = 1'b0;
    endtask

    task automatic test_backpressure();
        net_ro = 1'b0; net_polarity = 1'b0;
        pe_write(2'b10, PKT_55);
        for (int i = 0; i < 3; i++) begin
            n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL bp_hold%0d_so got %b exp 0", i, net_so); end
            tick();
        end
        net_ro = 1'b1; #1;
        n_cmp++; if (net_so !== 1'b1) begin n_bad++; $display("FAIL bp_release_so got %b exp 1", net_so); end
        n_cmp++; if (net_do !== PKT_55) begin n_bad++; $display("FAIL bp_do got %h exp %h", net_do, PKT_55); end
        tick();
        n_cmp++; if (net_so !== 1'b0) begin n_bad++; $display("FAIL bp_after_so got %b exp 0", net_so); end
        net_ro = 1'b0;
    endtask

    task automatic test_write_full();
        net_ro = 1'b0; net_polarity = 1'b1;
        pe_write(2'b10, PKT_11);
        pe_write(2'b10, 64'h1);
        pe_read(2'b11);
        n_cmp++; if (d_out !== 64'h1) begin n_bad++; $display("FAIL wf_outstat got %h exp 1", d_out); end
        n_cmp++; if (net_do !== PKT_11) begin n_bad++; $display("FAIL wf_keep got %h exp %h", net_do, PKT_11); end
        net_ro = 1'b1; #1;
        n_cmp++; if (net_so !== 1'b1) begin n_bad++; $display("FAIL wf_so got %b exp 1", net_so); end
        // Write collides with the injecting cycle and must be dropped.
        pe_write(2'b10, 64'h2);
        net_ro = 1'b0;
        pe_read(2'b11);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL wf_collide_stat got %h exp 0", d_out); end
        n_cmp++; if (net_do !== PKT_11) begin n_bad++; $display("FAIL wf_collide_do got %h exp %h", net_do, PKT_11); end
    endtask

    task automatic test_receive();
        net_si = 1'b1; net_di = PKT_RX; #1;
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL rx_ready got %b exp 1", net_ri); end
        tick();
        net_di = PKT_RX2; #1;
        n_cmp++; if (net_ri !== 1'b0) begin n_bad++; $display("FAIL rx_full_ri got %b exp 0", net_ri); end
        tick();
        net_si = 1'b0;
        pe_read(2'b01);
        n_cmp++; if (d_out !== 64'h1) begin n_bad++; $display("FAIL rx_instat got %h exp 1", d_out); end
        pe_read(2'b00);
        n_cmp++; if (d_out !== PKT_RX) begin n_bad++; $display("FAIL rx_data got %h exp %h", d_out, PKT_RX); end
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL rx_reopen got %b exp 1", net_ri); end
        pe_read(2'b01);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL rx_instat_clr got %h exp 0", d_out); end
        pe_read(2'b00);
        n_cmp++; if (d_out !== PKT_RX) begin n_bad++; $display("FAIL rx_stale got %h exp %h", d_out, PKT_RX); end
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL rx_stale_ri got %b exp 1", net_ri); end
    endtask

    task automatic test_illegal();
        tick();
        n_cmp++; if (d_out !== PKT_RX) begin n_bad++; $display("FAIL il_hold_idle got %h exp %h", d_out, PKT_RX); end
        pe_write(2'b01, 64'hDEAD);
        pe_write(2'b00, 64'hBEEF);
        pe_write(2'b11, 64'hCAFE);
        n_cmp++; if (d_out !== PKT_RX) begin n_bad++; $display("FAIL il_hold_wr got %h exp %h", d_out, PKT_RX); end
        n_cmp++; if (net_do !== PKT_11) begin n_bad++; $display("FAIL il_outbuf got %h exp %h", net_do, PKT_11); end
        n_cmp++; if (net_ri !== 1'b1) begin n_bad++; $display("FAIL il_ri got %b exp 1", net_ri); end
        pe_read(2'b10);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL il_rd10 got %h exp 0", d_out); end
        pe_read(2'b11);
        n_cmp++; if (d_out !== 64'h0) begin n_bad++; $display("FAIL il_outstat got %h exp 0", d_out); end
        pe_read(2'b00);
        n_cmp++; if (d_out !== PKT_RX) begin n_bad++; $display("FAIL il_inbuf got %h exp %h", d_out, PKT_RX); end
    endtask

    initial begin
        rst = 1'b1; addr = 2'b00; d_in = '0; nicEn = 1'b0; nicEnWr = 1'b0;
        net_si = 1'b0; net_di = '0; net_ro = 1'b0; net_polarity = 1'b0;
        test_reset();
        test_injection();
        test_backpressure();
        test_write_full();
        test_receive();
        test_illegal();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
